// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV64I constants and types for the integer register
//               file: data width, register count, index/word typedefs, the
//               hard-wired zero register index and a one-hot decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int LARGURA  = 64;
  localparam int NUM_REGS = 32;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef logic [IDX_W-1:0]   reg_idx_t;
  typedef logic [LARGURA-1:0] palavra_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  // One-hot decode of a register index into a NUM_REGS-wide mask.
  function automatic logic [NUM_REGS-1:0] onehot(input reg_idx_t idx);
    logic [NUM_REGS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/placar_pendencias.sv
`default_nettype none
// ============================================================================
// Module      : placar_pendencias
// Description : Load-use scoreboard. One pending bit per architectural
//               register (bit 0 hard-wired to 0). A load issue sets the bit
//               of its destination, a writeback clears it; when both hit the
//               same index in one cycle the set wins, because the newer load
//               now owns the register. bolha flags a read of a pending reg.
// Ports       : clock, reset       - rising-edge clock, async active-high reset
//               marca_en/marca_idx - set request (load issued)
//               limpa_en/limpa_idx - clear request (writeback, idx != 0)
//               mascara_bypass     - bits being cleared this cycle that must
//                                    not count toward bolha (all 0 when the
//                                    write-through path is not built)
//               rs1, rs2           - read indices under test
//               bolha              - stall request
// Revision    : 1.0 - initial release
// ============================================================================
module placar_pendencias
  import riscv_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                marca_en,
  input  reg_idx_t            marca_idx,
  input  logic                limpa_en,
  input  reg_idx_t            limpa_idx,
  input  logic [NUM_REGS-1:0] mascara_bypass,
  input  reg_idx_t            rs1,
  input  reg_idx_t            rs2,
  output logic                bolha
);

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_next;
  logic [NUM_REGS-1:0] pend_visivel;

  // Clear is applied first so that a same-index set overrides it.
  always_comb begin
    pend_next = pend;
    if (limpa_en) pend_next[limpa_idx] = 1'b0;
    if (marca_en) pend_next[marca_idx] = 1'b1;
    pend_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pend <= '0;
    else       pend <= pend_next;
  end

  assign pend_visivel = pend & ~mascara_bypass;
  assign bolha        = pend_visivel[rs1] | pend_visivel[rs2];

endmodule : placar_pendencias
`default_nettype wire

// File: rtl/banco_registradores.sv
`default_nettype none
// ============================================================================
// Module      : banco_registradores
// Description : 32 x 64-bit RV64I integer register file with two
//               combinational read ports, one writeback port and a load-use
//               scoreboard. x0 is not stored: it always reads 0 and writes
//               to it are dropped.
//               Build option: REGFILE_BYPASS_EN - same-cycle write-through
//               of the writeback data to the read ports, and the pending bit
//               being cleared this cycle no longer raises bolha.
// Ports       : clock, reset          - rising-edge clock, async active-high
//               rs1/dado1, rs2/dado2  - read ports (dado2 feeds operand mux)
//               regWrite/rd/dadoEscrita - writeback port
//               marcaPendente/rdPendente - load issue into the scoreboard
//               bolha                 - stall: rs1 or rs2 pending
// Revision    : 1.0 - initial release
// ============================================================================
module banco_registradores
  import riscv_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  output palavra_t dado1,
  output palavra_t dado2,
  input  logic     regWrite,
  input  reg_idx_t rd,
  input  palavra_t dadoEscrita,
  input  logic     marcaPendente,
  input  reg_idx_t rdPendente,
  output logic     bolha
);

  palavra_t            regs [1:NUM_REGS-1];
  logic                escrita_valida;
  logic                marca_valida;
  logic [NUM_REGS-1:0] mascara_bypass;

  assign escrita_valida = regWrite && (rd != REG_ZERO);
  assign marca_valida   = marcaPendente && (rdPendente != REG_ZERO);

  // --------------------------------------------------------------------------
  // Storage: x1..x31 only.
  // --------------------------------------------------------------------------
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        regs[i] <= '0;
      else if (escrita_valida && (rd == reg_idx_t'(i)))
        regs[i] <= dadoEscrita;
    end
  end

  // --------------------------------------------------------------------------
  // Read muxes. Default 0 covers x0.
  // --------------------------------------------------------------------------
  always_comb begin
    dado1 = '0;
    dado2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs1 == reg_idx_t'(i)) dado1 = regs[i];
      if (rs2 == reg_idx_t'(i)) dado2 = regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    // Write-through is gated by reset so outputs stay 0 while it is held.
    if (!reset && escrita_valida && (rd == rs1)) dado1 = dadoEscrita;
    if (!reset && escrita_valida && (rd == rs2)) dado2 = dadoEscrita;
`endif
  end

`ifdef REGFILE_BYPASS_EN
  assign mascara_bypass = escrita_valida ? onehot(rd) : '0;
`else
  assign mascara_bypass = '0;
`endif

  placar_pendencias u_placar (
    .clock          (clock),
    .reset          (reset),
    .marca_en       (marca_valida),
    .marca_idx      (rdPendente),
    .limpa_en       (escrita_valida),
    .limpa_idx      (rd),
    .mascara_bypass (mascara_bypass),
    .rs1            (rs1),
    .rs2            (rs2),
    .bolha          (bolha)
  );

endmodule : banco_registradores
`default_nettype wire

// File: tb/tb_banco_registradores.sv
`default_nettype none
// ============================================================================
// Module      : tb_banco_registradores
// Description : Self-checking bench for banco_registradores. A driver issues
//               one stimulus per cycle shortly after the rising edge, computes
//               the expected read/stall response from an array-based model of
//               the register file and pending set, and queues it; a monitor
//               on the falling edge pops and compares. Honors
//               REGFILE_BYPASS_EN in the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banco_registradores;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, rdPendente = '0;
  logic [63:0] dado1, dado2, dadoEscrita = '0;
  logic        regWrite = 1'b0, marcaPendente = 1'b0, bolha;

  always #5 clock = ~clock;

  banco_registradores dut (
    .clock         (clock),
    .reset         (reset),
    .rs1           (rs1),
    .rs2           (rs2),
    .dado1         (dado1),
    .dado2         (dado2),
    .regWrite      (regWrite),
    .rd            (rd),
    .dadoEscrita   (dadoEscrita),
    .marcaPendente (marcaPendente),
    .rdPendente    (rdPendente),
    .bolha         (bolha)
  );

  typedef struct {
    logic [63:0] d1;
    logic [63:0] d2;
    logic        b;
    logic [4:0]  r1;
    logic [4:0]  r2;
  } exp_t;

  exp_t        fila[$];
  logic [63:0] m_reg  [32];
  bit          m_pend [32];
  int          checks = 0;
  int          passed = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // One stimulus cycle: drive, predict, then advance the model by one edge.
  task automatic ciclo(input bit rst, input logic [4:0] a1, input logic [4:0] a2,
                       input bit we, input logic [4:0] wi, input logic [63:0] wd,
                       input bit mk, input logic [4:0] mi);
    exp_t e;
    bit   wr_ok;
    @(posedge clock);
    #1;
    reset = rst; rs1 = a1; rs2 = a2;
    regWrite = we; rd = wi; dadoEscrita = wd;
    marcaPendente = mk; rdPendente = mi;
    if (rst) begin
      for (int k = 0; k < 32; k++) begin m_reg[k] = '0; m_pend[k] = 0; end
    end
    wr_ok = !rst && we && (wi != 0);
    e.r1 = a1; e.r2 = a2;
    e.d1 = (a1 == 0) ? 64'd0 : m_reg[a1];
    e.d2 = (a2 == 0) ? 64'd0 : m_reg[a2];
    if (BYPASS && wr_ok && wi == a1) e.d1 = wd;
    if (BYPASS && wr_ok && wi == a2) e.d2 = wd;
    e.b = (m_pend[a1] && !(BYPASS && wr_ok && wi == a1)) ||
          (m_pend[a2] && !(BYPASS && wr_ok && wi == a2));
    fila.push_back(e);
    if (!rst) begin
      if (wr_ok) begin m_reg[wi] = wd; m_pend[wi] = 0; end
      if (mk && mi != 0) m_pend[mi] = 1;
    end
  endtask

  task automatic ler(input logic [4:0] a1, input logic [4:0] a2);
    ciclo(0, a1, a2, 0, 5'd0, 64'd0, 0, 5'd0);
  endtask

  // Monitor: every falling edge the DUT outputs are valid for the queued entry.
  always @(negedge clock) begin
    exp_t e;
    if (fila.size() > 0) begin
      e = fila.pop_front();
      checks++;
      if (dado1 === e.d1) passed++;
      else $display("FAIL dado1 rs1=%0d got=%h exp=%h", e.r1, dado1, e.d1);
      checks++;
      if (dado2 === e.d2) passed++;
      else $display("FAIL dado2 rs2=%0d got=%h exp=%h", e.r2, dado2, e.d2);
      checks++;
      if (bolha === e.b) passed++;
      else $display("FAIL bolha rs1=%0d rs2=%0d got=%b exp=%b", e.r1, e.r2, bolha, e.b);
    end
  end

  initial begin
    for (int k = 0; k < 32; k++) begin m_reg[k] = '0; m_pend[k] = 0; end

    // Reset held (with a write/mark that must be lost), then released.
    ciclo(1, 5'd5, 5'd6, 1, 5'd5, 64'hAAAA, 1, 5'd6);
    ciclo(1, 5'd0, 5'd1, 0, 5'd0, 64'd0, 0, 5'd0);
    for (int k = 0; k < 32; k += 2) ler(5'(k), 5'(k + 1));

    // Basic write then read on both ports.
    ciclo(0, 5'd0, 5'd0, 1, 5'd5, 64'hDEAD_BEEF_0123_4567, 0, 5'd0);
    ler(5'd5, 5'd5);
    ciclo(0, 5'd0, 5'd0, 1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 5'd0);
    ler(5'd0, 5'd0);

    // Same-cycle write and read of x7.
    ciclo(0, 5'd0, 5'd7, 1, 5'd7, 64'h42, 0, 5'd0);
    ler(5'd0, 5'd7);

    // Load-use on x9: mark, wait, writeback, observe.
    ciclo(0, 5'd9, 5'd0, 0, 5'd0, 64'd0, 1, 5'd9);
    ler(5'd9, 5'd0);
    ler(5'd9, 5'd0);
    ciclo(0, 5'd9, 5'd0, 1, 5'd9, 64'h99, 0, 5'd0);
    ler(5'd9, 5'd0);

    // Set and clear x12 together: set wins.
    ciclo(0, 5'd0, 5'd0, 1, 5'd12, 64'h12, 1, 5'd12);
    ler(5'd0, 5'd12);
    ciclo(0, 5'd0, 5'd12, 1, 5'd12, 64'h13, 0, 5'd0);
    // Set and clear on different indices together.
    ciclo(0, 5'd0, 5'd0, 0, 5'd0, 64'd0, 1, 5'd14);
    ciclo(0, 5'd14, 5'd15, 1, 5'd14, 64'h14, 1, 5'd15);
    ler(5'd14, 5'd15);
    ler(5'd14, 5'd0);
    // Mark x0 never stalls.
    ciclo(0, 5'd0, 5'd0, 0, 5'd0, 64'd0, 1, 5'd0);
    ler(5'd0, 5'd0);

    // Asynchronous reset mid-cycle.
    ciclo(0, 5'd0, 5'd0, 1, 5'd3, 64'h1, 1, 5'd4);
    ler(5'd4, 5'd3);
    ciclo(1, 5'd4, 5'd3, 1, 5'd3, 64'h5, 1, 5'd4);
    ler(5'd4, 5'd3);
    ler(5'd4, 5'd3);

    // Randomized traffic, biased toward a few hot registers.
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  a1, a2, wi, mi;
      logic [63:0] wd;
      bit          we, mk, rst;
      a1  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a2  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wi  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      mi  = 5'($urandom_range(0, 7));
      wd  = {$urandom, $urandom};
      we  = ($urandom_range(0, 2) != 0);
      mk  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 63) == 0);
      ciclo(rst, a1, a2, we, wi, wd, mk, mi);
    end
    ler(5'd0, 5'd0);

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 5 && fila.size() > 0; t++) @(posedge clock);
    if (fila.size() != 0) begin
      checks++;
      $display("FAIL drain pending=%0d required=0", fila.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_banco_registradores
`default_nettype wire

// File: doc/banco_registradores.md
# banco_registradores

32 × 64-bit RV64I integer register file with load-use scoreboard. It sits directly upstream of the ALU operand mux: `dado2` feeds the mux's register-operand input, and `dado1` feeds the ALU's first operand. It accepts one writeback per cycle and provides two asynchronous reads. It also tracks registers that are destinations of in-flight loads, so the control unit can stall.

## Interface
- `LARGURA`, 64: data width in bits.
- `NUM_REGS`, 32: number of architectural registers; index width is log2(`NUM_REGS`) = 5.

Ports:
- `clock` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `rs1` input 5: read-port-1 register index.
- `rs2` input 5: read-port-2 register index.
- `dado1` output 64: read data, port 1.
- `dado2` output 64: read data, port 2; drives the operand mux.
- `regWrite` input 1: writeback enable.
- `rd` input 5: writeback register index.
- `dadoEscrita` input 64: writeback data.
- `marcaPendente` input 1: a load is issued this cycle with destination `rdPendente`.
- `rdPendente` input 5: destination index of the issuing load.
- `bolha` output 1: a stall is required because `rs1` or `rs2` is pending.

## Operation
- **Storage:** x1–x31 are 64-bit flops. x0 is not stored.
  - A read of index 0 always returns 0.
  - A write to index 0 is discarded.
- **Reads:** combinational. `dado1` = reg[`rs1`] and `dado2` = reg[`rs2`].
- **Writes:** when `regWrite`=1 and `rd`≠0, reg[`rd`] ← `dadoEscrita` at the rising edge.
- **Scoreboard:** 32 pending bits; bit 0 is constant 0.
  - Set: `marcaPendente`=1 and `rdPendente`≠0 sets bit[`rdPendente`] at the edge.
  - Clear: `regWrite`=1 and `rd`≠0 clears bit[`rd`] at the edge.
  - Set and clear on the same index in the same cycle: **set wins**. The older writeback completes, and the newer load now owns the register.
  - Set and clear on different indices in the same cycle: both take effect.
- **Stall:** `bolha` = pend[`rs1`] | pend[`rs2`], evaluated on current-cycle bit state.
  - A pending bit cleared by the writeback happening in this same cycle still counts as pending, unless `REGFILE_BYPASS_EN` is defined (see Configuration).
- **Arithmetic:** no arithmetic. Data is passed unchanged, with no sign or width conversion.

## Timing
- **Reset:** asynchronous. While `reset`=1, all registers and pending bits are 0, so `dado1`=`dado2`=0 and `bolha`=0.
  - A write or mark presented during reset is lost.
  - Deassertion takes effect at the next edge.
- **Write-to-read latency:** 1 cycle. Data written at edge N is visible on `dado1`/`dado2` after edge N.
- **Scoreboard latency:** a set at edge N raises `bolha` for matching readers from cycle N+1 onward.
- **Read-port independence:** `rs1`=`rs2` returns identical data on both ports.
- **Reset mid-operation:** all pending bits clear. The upstream pipeline must flush in-flight loads on the same reset.

## Configuration
- `REGFILE_BYPASS_EN` defined: same-cycle write-through.
  - If `regWrite`=1, `rd`≠0 and `rd`=`rs1`, then `dado1`=`dadoEscrita`. The same rule applies to `rs2` and `dado2`.
  - A pending bit being cleared this cycle does not contribute to `bolha`.
  - x0 is never bypassed.
- `REGFILE_BYPASS_EN` undefined:
  - Reads return pre-edge contents.
  - `bolha` remains asserted through the writeback cycle, costing one extra stall cycle per load-use.

## Structure
- Shared package `riscv_pkg`:
  - `LARGURA` and `NUM_REGS` constants.
  - `reg_idx_t` (5-bit index typedef).
  - `palavra_t` (64-bit word typedef).
  - `REG_ZERO` = 5'd0.
- One sub-module, `placar_pendencias`:
  - Contains the 32-bit pending vector, the set/clear priority logic and the `bolha` generation.
  - Takes the bypass-clear mask as an input.
- The storage array and read muxing stay in the top module.

## Test plan
- Reset held, then released; read all 32 indices → every read is 0 and `bolha`=0.
- Write 64'hDEAD_BEEF_0123_4567 to x5, then read with `rs1`=`rs2`=5 on the next cycle → both ports return that value.
  - Write 64'hFFFF… to x0 → reads of x0 return 0.
- Same-cycle `regWrite`, `rd`=7, data 64'h42, with `rs2`=7:
  - With the macro defined → `dado2`=64'h42 in that cycle.
  - Without the macro → old value, then 64'h42 after the edge.
- `marcaPendente` with `rdPendente`=9 at edge N, and `rs1`=9 → `bolha`=1 from N+1.
  - Writeback to x9 at edge M → `bolha` drops after M without the macro, and in the writeback cycle M itself with the macro.
- Same cycle: mark x12 and writeback x12 → pending stays 1 and `bolha`=1 next cycle for `rs2`=12.
  - Mark x0 → `bolha` never asserts.
- Write x3=64'h1 and mark x4, then assert `reset` mid-cycle asynchronously → outputs are 0 immediately.
  - After deassert, x3 reads 0 and `bolha`=0 for `rs1`=4.
